instruction_fetch_unit: RTL and testbench

Fetch controller between `programCounter` and the instruction memory. Each cycle it takes the current PC and issues a word read to instruction memory over a request/response handshake. It holds the returned word in an instruction register for decode and drives `freeze` back to `programCounter` so the PC advances only when decode consumes an instruction or a redirect occurs. It also detects misaligned PCs and, optionally, memory timeouts.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_timeout_counter.sv | 19 +
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int FETCH_TIMEOUT_W = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DRAIN,
    ST_HOLD,
    ST_ERR
  } fetch_state_t;
  typedef enum logic [1:0] {
    FETCH_ERR_NONE     = 2'd0,
    FETCH_ERR_MISALIGN = 2'd1,
    FETCH_ERR_TIMEOUT  = 2'd2
  } fetch_err_t;
endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: counts cycles spent awaiting a response; expired_o flags the limit-th cycle.
module fetch_timeout_counter
  import fetch_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic [FETCH_TIMEOUT_W-1:0] limit_i,
  output logic                       expired_o
);
  logic [FETCH_TIMEOUT_W-1:0] cnt_q;
  // cnt_q is the number of completed cycles, so the current cycle is cnt_q+1
  assign expired_o = ({1'b0, cnt_q} + 9'd1) >= {1'b0, limit_i};
  always_ff @(posedge clk) begin
    if (reset || clear_i) cnt_q <= '0;
    else if (enable_i && !expired_o) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC-driven instruction fetch over a req/rsp handshake with decode holding register.
// Optional response timeout is built when FETCH_TIMEOUT_EN is defined.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ready_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic              freeze_o,
  output logic [1:0]        fetch_err_o
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("instruction_fetch_unit: TIMEOUT_CYCLES must be within 2..255");
  end
  fetch_state_t      state_q, state_d;
  fetch_err_t        err_q, err_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misaligned;
  logic              timeout;
  assign misaligned = pc_i[1:0] != 2'b00;
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (!flush_i && misaligned) begin
          state_d = ST_ERR;
          err_d   = FETCH_ERR_MISALIGN;
        end else if (!flush_i && imem_ready_i) begin
          state_d = ST_WAIT;
          pc_d    = pc_i;
        end
      end
      ST_WAIT: begin
        if (flush_i) state_d = imem_rvalid_i ? ST_REQ : ST_DRAIN;
        else if (imem_rvalid_i) begin
          state_d = ST_HOLD;
          instr_d = imem_rdata_i;
        end else if (timeout) begin
          state_d = ST_ERR;
          err_d   = FETCH_ERR_TIMEOUT;
        end
      end
      // the outstanding response belongs to a discarded fetch
      ST_DRAIN: begin
        if (imem_rvalid_i) state_d = ST_REQ;
        else if (timeout) begin
          state_d = ST_ERR;
          err_d   = FETCH_ERR_TIMEOUT;
        end
      end
      ST_HOLD: state_d = (flush_i || instr_ready_i) ? ST_REQ : ST_HOLD;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= FETCH_ERR_NONE;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end
`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_counter u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_d != state_q && (state_d == ST_WAIT || state_d == ST_DRAIN)),
    .enable_i  (state_q == ST_WAIT || state_q == ST_DRAIN),
    .limit_i   (FETCH_TIMEOUT_W'(TIMEOUT_CYCLES)),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  assign imem_req_o    = state_q == ST_REQ && !flush_i && !misaligned;
  assign imem_addr_o   = {pc_i[ADDR_W-1:2], 2'b00};
  assign instr_o       = instr_q;
  assign instr_pc_o    = pc_q;
  assign instr_valid_o = state_q == ST_HOLD;
  assign freeze_o      = state_q == ST_ERR || !((state_q == ST_HOLD && instr_ready_i) || flush_i);
  assign fetch_err_o   = err_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        valid;
  logic        iready;
  logic        freeze;
  logic [1:0]  err;
  int n_tests = 0;
  int n_fail  = 0;
  always #5 clk = ~clk;
  instruction_fetch_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_i          (pc),
    .flush_i       (flush),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_ready_i  (ready),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (valid),
    .instr_ready_i (iready),
    .freeze_o      (freeze),
    .fetch_err_o   (err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    reset = 1; pc = 0; flush = 0; ready = 0; rvalid = 0; rdata = 0; iready = 0;
    tick(); tick();
    #1;
    check("rst_req", 32'(req), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_freeze", 32'(freeze), 1);
    check("rst_err", 32'(err), 0);
    check("rst_instr", instr, 0);
    reset = 0;
    tick();
    ready = 1; #1;
    check("bf_req", 32'(req), 1);
    check("bf_addr", addr, 0);
    check("bf_freeze_req", 32'(freeze), 1);
    tick();
    ready = 0; rvalid = 1; rdata = 32'h2010_0005; #1;
    check("bf_wait_valid", 32'(valid), 0);
    check("bf_wait_req", 32'(req), 0);
    tick();
    rvalid = 0; #1;
    check("bf_valid", 32'(valid), 1);
    check("bf_instr", instr, 32'h2010_0005);
    check("bf_instr_pc", instr_pc, 0);
    check("bf_freeze_hold", 32'(freeze), 1);
    iready = 1; #1;
    check("bf_freeze_consume", 32'(freeze), 0);
    tick();
    iready = 0; pc = 32'h4; #1;
    check("bf_valid_drop", 32'(valid), 0);
    check("bf_freeze_after", 32'(freeze), 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req", 32'(req), 1);
      check("bp_addr", addr, 32'h4);
      check("bp_freeze", 32'(freeze), 1);
      tick();
    end
    ready = 1;
    tick();
    ready = 0; rvalid = 1; rdata = 32'hA5A5_0013;
    tick();
    rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_instr", instr, 32'hA5A5_0013);
      check("bp_instr_pc", instr_pc, 32'h4);
      check("bp_valid", 32'(valid), 1);
      tick();
    end
    iready = 1;
    tick();
    iready = 0;
    flush = 1; #1;
    check("fl_req_noreq", 32'(req), 0);
    check("fl_req_freeze", 32'(freeze), 0);
    tick();
    flush = 0; #1;
    check("fl_req_stay", 32'(req), 1);
    pc = 32'h10; ready = 1;
    tick();
    ready = 0; flush = 1; #1;
    check("fl_wait_freeze", 32'(freeze), 0);
    tick();
    flush = 0; pc = 32'h40; #1;
    check("fl_drain_valid", 32'(valid), 0);
    check("fl_drain_req", 32'(req), 0);
    tick();
    rvalid = 1; rdata = 32'hDEAD_0001; #1;
    check("fl_drain_valid2", 32'(valid), 0);
    tick();
    rvalid = 0; #1;
    check("fl_discard_valid", 32'(valid), 0);
    check("fl_discard_instr", instr, 32'hA5A5_0013);
    check("fl_redirect_req", 32'(req), 1);
    check("fl_redirect_addr", addr, 32'h40);
    ready = 1;
    tick();
    ready = 0; #1;
    check("fl_redirect_pc", instr_pc, 32'h40);
    rvalid = 1; rdata = 32'h0000_0013;
    tick();
    rvalid = 0; #1;
    check("fl_new_instr", instr, 32'h0000_0013);
    check("fl_new_valid", 32'(valid), 1);
    flush = 1; iready = 1; #1;
    check("fl_hold_freeze", 32'(freeze), 0);
    tick();
    flush = 0; iready = 0; #1;
    check("fl_hold_valid", 32'(valid), 0);
    pc = 32'h44; ready = 1;
    tick();
    ready = 0; flush = 1; rvalid = 1; rdata = 32'hBEEF_0000;
    tick();
    flush = 0; rvalid = 0; #1;
    check("fl_same_req", 32'(req), 1);
    check("fl_same_valid", 32'(valid), 0);
    pc = 32'h48; ready = 1;
`ifdef FETCH_TIMEOUT_EN
    tick();
    ready = 0;
    repeat (3) tick();
    #1;
    check("to_edge_err", 32'(err), 0);
    rvalid = 1; rdata = 32'h0000_0055;
    tick();
    rvalid = 0; #1;
    check("to_edge_valid", 32'(valid), 1);
    check("to_edge_instr", instr, 32'h0000_0055);
    check("to_edge_noerr", 32'(err), 0);
    iready = 1;
    tick();
    iready = 0; ready = 1;
    tick();
    ready = 0;
    repeat (3) tick();
    #1;
    check("to_pre_err", 32'(err), 0);
    tick();
    #1;
    check("to_err", 32'(err), 2);
    check("to_req", 32'(req), 0);
    flush = 1; #1;
    check("to_freeze", 32'(freeze), 1);
    flush = 0; reset = 1;
    tick();
    reset = 0;
    tick();
`else
    tick();
    ready = 0;
    repeat (10) tick();
    #1;
    check("nto_err", 32'(err), 0);
    check("nto_valid", 32'(valid), 0);
    check("nto_req", 32'(req), 0);
    rvalid = 1; rdata = 32'h0000_0055;
    tick();
    rvalid = 0; #1;
    check("nto_late_valid", 32'(valid), 1);
    check("nto_late_instr", instr, 32'h0000_0055);
    iready = 1;
    tick();
    iready = 0;
`endif
    pc = 32'h6; ready = 1; #1;
    check("mis_noreq", 32'(req), 0);
    tick();
    ready = 0; #1;
    check("mis_err", 32'(err), 1);
    check("mis_req", 32'(req), 0);
    check("mis_valid", 32'(valid), 0);
    pc = 32'h8; ready = 1; flush = 1; rvalid = 1;
    repeat (3) tick();
    #1;
    check("mis_sticky", 32'(err), 1);
    check("mis_sticky_req", 32'(req), 0);
    check("mis_sticky_freeze", 32'(freeze), 1);
    check("mis_sticky_valid", 32'(valid), 0);
    flush = 0; ready = 0; rvalid = 0; reset = 1;
    tick();
    #1;
    check("mis_reset_err", 32'(err), 0);
    reset = 0;
    tick();
    ready = 1;
    tick();
    ready = 0; reset = 1;
    tick();
    #1;
    check("rw_req", 32'(req), 0);
    check("rw_valid", 32'(valid), 0);
    check("rw_freeze", 32'(freeze), 1);
    check("rw_err", 32'(err), 0);
    check("rw_instr", instr, 0);
    check("rw_instr_pc", instr_pc, 0);
    reset = 0; pc = 0; rvalid = 1; rdata = 32'h0BAD_0BAD;
    tick();
    rvalid = 0; #1;
    check("rw_late_valid", 32'(valid), 0);
    check("rw_late_instr", instr, 0);
    check("rw_next_req", 32'(req), 1);
    check("rw_next_addr", addr, 0);
    ready = 1;
    tick();
    ready = 0; #1;
    check("rw_next_pc", instr_pc, 0);
    rvalid = 1; rdata = 32'h0000_0093;
    tick();
    rvalid = 0; #1;
    check("rw_next_instr", instr, 32'h0000_0093);
    check("rw_next_valid", 32'(valid), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
